// File: rtl/bus_arbiter_pkg.sv
// Shared bus definitions: arbiter state encoding, bus widths, default grant timeout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bus_arbiter_pkg;

   localparam int ADDR_W          = 8;
   localparam int DATA_W          = 8;
   localparam int TIMEOUT_DEFAULT = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } arb_state_t;

endpackage

// File: rtl/bus_arbiter_if.sv
// Two-master bus bundle: per-master request/grant/address/strobes/data plus the shared slave bus.
// Latency: n/a (wiring only).
// Backpressure: a master holds its request until granted; a grant holds while the request stays high.
// Modports: master = request side (CPU/DMA models), slave = arbiter side.
interface bus_arbiter_if;
   import bus_arbiter_pkg::*;

   logic              m0_req;
   logic              m0_grant;
   logic [ADDR_W-1:0] m0_addr;
   logic              m0_wr;
   logic              m0_rd;
   logic [DATA_W-1:0] m0_data;

   logic              m1_req;
   logic              m1_grant;
   logic [ADDR_W-1:0] m1_addr;
   logic              m1_wr;
   logic              m1_rd;
   logic [DATA_W-1:0] m1_data;

   logic [ADDR_W-1:0] s_addr;
   logic              s_wr;
   logic              s_rd;
   logic [DATA_W-1:0] s_data;
   logic              arb_busy;

   modport master (
      output m0_req, m0_addr, m0_wr, m0_rd, m0_data,
      output m1_req, m1_addr, m1_wr, m1_rd, m1_data,
      input  m0_grant, m1_grant, s_addr, s_wr, s_rd, s_data, arb_busy
   );

   modport slave (
      input  m0_req, m0_addr, m0_wr, m0_rd, m0_data,
      input  m1_req, m1_addr, m1_wr, m1_rd, m1_data,
      output m0_grant, m1_grant, s_addr, s_wr, s_rd, s_data, arb_busy
   );

endinterface

// File: rtl/arb_wait_counter.sv
// Counts consecutive cycles the non-granted master has been waiting; flags when TIMEOUT is reached.
// Latency: timeout_hit is combinational from the count, so the handover lands on the TIMEOUT-th waiting edge.
// Backpressure: none; clears whenever the waiter drops its request or the grant moves.
// Ports: clk, rst (async active-low), wait_vld (other master waiting), state_chg, timeout_hit.
module arb_wait_counter
   import bus_arbiter_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic wait_vld,
   input  logic state_chg,
   output logic timeout_hit
);

   // Holds the number of waiting cycles already completed; TIMEOUT <= 255 fits in 8 bits.
   logic [7:0] cnt;

   // The current cycle is the TIMEOUT-th waiting cycle when TIMEOUT-1 have already elapsed.
   assign timeout_hit = wait_vld && (cnt == 8'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (state_chg || !wait_vld) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 8'd1;
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter (CPU = m0, DMA/debug = m1) with round-robin tie-break and slave-side mux.
// Latency: request sampled at edge N -> registered grant after edge N; slave bus muxed combinationally.
// Backpressure: grant held while req stays high; optional forced handover after TIMEOUT waiting
// cycles when BUS_ARB_TIMEOUT_EN is defined (otherwise TIMEOUT is only range-checked).
// Ports: clk, rst (async active-low), bus (bus_arbiter_if.slave).
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   bus_arbiter_if.slave bus
);

   if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
      $error("bus_arbiter: TIMEOUT must be within 2..255");
   end

   arb_state_t state;
   arb_state_t state_nxt;
   logic       rr_ptr;       // master to pick on a tie in IDLE: the one not most recently granted
   logic       timeout_hit;

`ifdef BUS_ARB_TIMEOUT_EN
   logic wait_vld;

   // The other master is waiting while we hold a grant.
   always_comb begin
      wait_vld = 1'b0;
      if (state == GNT0) begin
         wait_vld = bus.m1_req;
      end else if (state == GNT1) begin
         wait_vld = bus.m0_req;
      end
   end

   arb_wait_counter #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_cnt (
      .clk         (clk),
      .rst         (rst),
      .wait_vld    (wait_vld),
      .state_chg   (state_nxt != state),
      .timeout_hit (timeout_hit)
   );
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         rr_ptr <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state_nxt == GNT0) begin
            rr_ptr <= 1'b1;
         end else if (state_nxt == GNT1) begin
            rr_ptr <= 1'b0;
         end
      end
   end

   // timeout_hit implies the other request is high, so it can only ever hand over, never idle.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (bus.m0_req && bus.m1_req) begin
               state_nxt = rr_ptr ? GNT1 : GNT0;
            end else if (bus.m0_req) begin
               state_nxt = GNT0;
            end else if (bus.m1_req) begin
               state_nxt = GNT1;
            end
         end
         GNT0: begin
            if (!bus.m0_req || timeout_hit) begin
               state_nxt = bus.m1_req ? GNT1 : IDLE;
            end
         end
         GNT1: begin
            if (!bus.m1_req || timeout_hit) begin
               state_nxt = bus.m0_req ? GNT0 : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.m0_grant = (state == GNT0);
   assign bus.m1_grant = (state == GNT1);
   assign bus.arb_busy = (state != IDLE);

   always_comb begin
      bus.s_addr = '0;
      bus.s_wr   = 1'b0;
      bus.s_rd   = 1'b0;
      bus.s_data = '0;
      case (state)
         GNT0: begin
            bus.s_addr = bus.m0_addr;
            bus.s_wr   = bus.m0_wr;
            bus.s_rd   = bus.m0_rd;
            bus.s_data = bus.m0_data;
         end
         GNT1: begin
            bus.s_addr = bus.m1_addr;
            bus.s_wr   = bus.m1_wr;
            bus.s_rd   = bus.m1_rd;
            bus.s_data = bus.m1_data;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios with literal expectations plus
// randomized request traffic compared every cycle against a bus-ownership model.
// Follows BUS_ARB_TIMEOUT_EN the same way the design does; instantiated with TIMEOUT=4.
module tb_bus_arbiter;

   localparam int TB_TIMEOUT = 4;
`ifdef BUS_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   bit   chk_en = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   bus_arbiter_if bus ();

   bus_arbiter #(
      .TIMEOUT (TB_TIMEOUT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Model: who owns the bus (-1 none, 0 or 1), who owned it last, and how many
   // consecutive cycles the other master has been kept waiting.
   int owner;
   int last;
   int waited;

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b expected=%b", name, act, exp);
      end
   endtask

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic model_step(input bit r0, input bit r1);
      bit r[2];
      int nxt;
      r[0] = r0;
      r[1] = r1;
      if (owner < 0) begin
         if (r0 && r1)  nxt = (last == 0) ? 1 : 0;
         else if (r0)   nxt = 0;
         else if (r1)   nxt = 1;
         else           nxt = -1;
      end else begin
         nxt = owner;
         if (!r[owner])
            nxt = r[1 - owner] ? 1 - owner : -1;
         else if (TO_EN && r[1 - owner] && (waited + 1 >= TB_TIMEOUT))
            nxt = 1 - owner;
      end
      if (nxt >= 0 && nxt == owner && r[1 - nxt]) waited++;
      else                                        waited = 0;
      if (nxt >= 0) last = nxt;
      owner = nxt;
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner  = -1;
         last   = -1;
         waited = 0;
      end else begin
         model_step(bus.m0_req, bus.m1_req);
      end
   end

   // Per-cycle compare against the model, plus the structural invariants.
   logic [7:0] e_addr, e_data;
   logic       e_wr, e_rd;
   always @(negedge clk) begin
      if (chk_en) begin
         e_addr = 8'h00; e_data = 8'h00; e_wr = 1'b0; e_rd = 1'b0;
         if (owner == 0) begin
            e_addr = bus.m0_addr; e_data = bus.m0_data; e_wr = bus.m0_wr; e_rd = bus.m0_rd;
         end else if (owner == 1) begin
            e_addr = bus.m1_addr; e_data = bus.m1_data; e_wr = bus.m1_wr; e_rd = bus.m1_rd;
         end
         check1("m0_grant", bus.m0_grant, owner == 0);
         check1("m1_grant", bus.m1_grant, owner == 1);
         check1("arb_busy", bus.arb_busy, owner >= 0);
         check8("s_addr", bus.s_addr, e_addr);
         check8("s_data", bus.s_data, e_data);
         check1("s_wr", bus.s_wr, e_wr);
         check1("s_rd", bus.s_rd, e_rd);
         check1("grant_mutex", bus.m0_grant & bus.m1_grant, 1'b0);
         if (!bus.arb_busy)
            check8("idle_bus_zero", {bus.s_wr, bus.s_rd, 6'd0} | bus.s_addr | bus.s_data, 8'h00);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.m0_req = 1'b0; bus.m0_addr = 8'h00; bus.m0_wr = 1'b0; bus.m0_rd = 1'b0; bus.m0_data = 8'h00;
      bus.m1_req = 1'b0; bus.m1_addr = 8'h00; bus.m1_wr = 1'b0; bus.m1_rd = 1'b0; bus.m1_data = 8'h00;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      clear_inputs();
      step(2);
      rst = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "bench did not finish");
   end

   initial begin
      rst = 1'b0;
      clear_inputs();
      step(3);

      // Reset state, with live master signals that must not leak to the slave bus.
      bus.m0_addr = 8'h3C; bus.m0_wr = 1'b1;
      bus.m1_addr = 8'hFF; bus.m1_wr = 1'b1;
      #1;
      check1("rst_m0_grant", bus.m0_grant, 1'b0);
      check1("rst_m1_grant", bus.m1_grant, 1'b0);
      check1("rst_busy", bus.arb_busy, 1'b0);
      check8("rst_s_addr", bus.s_addr, 8'h00);
      check1("rst_s_wr", bus.s_wr, 1'b0);
      step(1);
      rst = 1'b1;
      chk_en = 1'b1;

      // Single CPU request: one-cycle latency, CPU address on the slave bus.
      bus.m0_req = 1'b1; bus.m0_data = 8'hA5;
      check1("lat_pre_m0_grant", bus.m0_grant, 1'b0);
      step(1);
      check1("single_m0_grant", bus.m0_grant, 1'b1);
      check1("single_m1_grant", bus.m1_grant, 1'b0);
      check8("single_s_addr", bus.s_addr, 8'h3C);
      check8("single_s_data", bus.s_data, 8'hA5);
      check1("single_busy", bus.arb_busy, 1'b1);
      bus.m0_req = 1'b0;
      step(1);
      check1("single_release_busy", bus.arb_busy, 1'b0);

      // Simultaneous requests after reset, direct handover, pointer tie-break.
      do_reset();
      bus.m0_req = 1'b1; bus.m1_req = 1'b1;
      step(1);
      check1("rr_m0_grant", bus.m0_grant, 1'b1);
      check1("rr_m1_grant", bus.m1_grant, 1'b0);
      bus.m0_req = 1'b0;
      step(1);
      check1("hand_m1_grant", bus.m1_grant, 1'b1);
      check1("hand_m0_grant", bus.m0_grant, 1'b0);
      check1("hand_busy", bus.arb_busy, 1'b1);
      bus.m1_req = 1'b0;
      step(1);
      check1("hand_idle_busy", bus.arb_busy, 1'b0);
      bus.m0_req = 1'b1; bus.m1_req = 1'b1;
      step(1);
      check1("rr2_m0_grant", bus.m0_grant, 1'b1);
      check1("rr2_m1_grant", bus.m1_grant, 1'b0);
      bus.m0_req = 1'b0; bus.m1_req = 1'b0;
      step(2);

      // CPU holds the bus; DMA requests from cycle 2 on.
      do_reset();
      bus.m0_req = 1'b1;
      step(2);
      bus.m1_req = 1'b1;
      step(3);
      check1("to_pre_m1_grant", bus.m1_grant, 1'b0);
      check1("to_pre_m0_grant", bus.m0_grant, 1'b1);
      step(1);
`ifdef BUS_ARB_TIMEOUT_EN
      check1("to_m1_grant", bus.m1_grant, 1'b1);
      check1("to_m0_grant", bus.m0_grant, 1'b0);
`else
      check1("hold_m0_grant", bus.m0_grant, 1'b1);
      check1("hold_m1_grant", bus.m1_grant, 1'b0);
      step(10);
      check1("hold_long_m1_grant", bus.m1_grant, 1'b0);
      bus.m0_req = 1'b0;
      step(1);
      check1("hold_rel_m1_grant", bus.m1_grant, 1'b1);
`endif
      bus.m0_req = 1'b0; bus.m1_req = 1'b0;
      step(2);

      // Reset asserted between edges while DMA is writing.
      do_reset();
      bus.m1_req = 1'b1; bus.m1_wr = 1'b1; bus.m1_addr = 8'h5A;
      step(1);
      check1("mid_m1_grant", bus.m1_grant, 1'b1);
      check1("mid_s_wr", bus.s_wr, 1'b1);
      #2;
      rst = 1'b0;
      #1;
      check1("async_m1_grant", bus.m1_grant, 1'b0);
      check1("async_busy", bus.arb_busy, 1'b0);
      check1("async_s_wr", bus.s_wr, 1'b0);
      bus.m1_req = 1'b0; bus.m0_req = 1'b1;
      step(1);
      rst = 1'b1;
      check1("post_rst_m0_pre", bus.m0_grant, 1'b0);
      step(1);
      check1("post_rst_m0_grant", bus.m0_grant, 1'b1);
      bus.m0_req = 1'b0;
      step(2);

      // Random traffic; requests toggle occasionally so long holds and timeouts occur.
      do_reset();
      for (int i = 0; i < 10000; i++) begin
         if ($urandom_range(7) == 0) bus.m0_req = ~bus.m0_req;
         if ($urandom_range(7) == 0) bus.m1_req = ~bus.m1_req;
         bus.m0_addr = 8'($urandom); bus.m0_data = 8'($urandom);
         bus.m0_wr   = 1'($urandom); bus.m0_rd   = 1'($urandom);
         bus.m1_addr = 8'($urandom); bus.m1_data = 8'($urandom);
         bus.m1_wr   = 1'($urandom); bus.m1_rd   = 1'($urandom);
         step(1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16, max consecutive granted cycles while the other master waits; legal range 2..255.
REQ-002 clk  in  1  system clock, all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 m0_req  in  1  bus request, master 0 (CPU).
REQ-005 m0_grant  out  1  bus grant, master 0.
REQ-006 m0_addr / m0_wr / m0_rd / m0_data  in  8/1/1/8  master 0 address, write strobe, read strobe, write data.
REQ-007 m1_req  in  1  bus request, master 1 (DMA/debug).
REQ-008 m1_grant  out  1  bus grant, master 1.
REQ-009 m1_addr / m1_wr / m1_rd / m1_data  in  8/1/1/8  master 1 address, write strobe, read strobe, write data.
REQ-010 s_addr / s_wr / s_rd / s_data  out  8/1/1/8  slave-side address, write, read, write data.
REQ-011 arb_busy  out  1  high while either grant is high.

Function
REQ-012 The arbiter SHALL implement three states: IDLE, GNT0, GNT1; m0_grant=(state==GNT0), m1_grant=(state==GNT1); both grants never high together.
REQ-013 Grants SHALL be registered: a request sampled at edge N yields a grant visible after edge N (one-cycle latency from req to grant).
REQ-014 IDLE: only m0_req -> GNT0; only m1_req -> GNT1; both -> the master indicated by the round-robin pointer; none -> stay IDLE.
REQ-015 Round-robin pointer SHALL point to the master not most recently granted; reset value points to master 0.
REQ-016 GNTx with req_x high SHALL hold GNTx (subject to REQ-019).
REQ-017 GNTx with req_x low SHALL go to the other GNT if the other req is high (direct handover, no idle cycle), else to IDLE.
REQ-018 Slave bus SHALL be a combinational mux of the granted master's addr/wr/rd/data; in IDLE all slave outputs SHALL be 0.
REQ-019 With BUS_ARB_TIMEOUT_EN: wait counter counts cycles in GNTx while the other req is high; on reaching TIMEOUT the state SHALL move to the other GNT next edge; counter clears on any state change or when the other req is low.
REQ-020 Request dropped and re-raised in the same cycle as a handover SHALL be treated as low (no glitch grant).

Reset
REQ-021 Reset SHALL asynchronously force state=IDLE, both grants 0, arb_busy 0, pointer to master 0, wait counter 0; all slave outputs 0.
REQ-022 Reset asserted mid-transfer SHALL drop the grant immediately without waiting for clk; the first request after release is served per REQ-013.

Configuration
REQ-023 Macro BUS_ARB_TIMEOUT_EN defined: the wait counter and forced handover of REQ-019 SHALL be present.
REQ-024 BUS_ARB_TIMEOUT_EN undefined: no counter is synthesised; a granted master keeps the bus until it drops req; TIMEOUT is ignored.

Structure
REQ-025 State encoding (IDLE=2'd0, GNT0=2'd1, GNT1=2'd2) and the TIMEOUT default SHALL live in the shared bus definitions include used by the CPU control definitions.
REQ-026 A single sub-module, arb_wait_counter, SHALL hold the timeout counter; it is instantiated only under BUS_ARB_TIMEOUT_EN.

Verification
REQ-027 m0_req=1 alone at cycle 0 -> m0_grant=1 from cycle 1; s_addr follows m0_addr=8'h3C; m1 addr 8'hFF not visible.
REQ-028 m0_req and m1_req both rise together after reset -> m0 granted; m0 drops req -> m1_grant=1 next cycle, no IDLE cycle; both requests rise together again -> m0 wins (pointer).
REQ-029 BUS_ARB_TIMEOUT_EN, TIMEOUT=4, m0 holds req and m1 requests at cycle 2 -> m1_grant=1 after 4 waiting cycles; m0_grant=0 same cycle.
REQ-030 Same as REQ-029 without the macro -> m0 holds the bus indefinitely; m1_grant stays 0 until m0_req=0.
REQ-031 rst driven low mid-GNT1 between clock edges -> m1_grant, arb_busy, s_wr go 0 immediately; after release with m0_req=1 -> m0_grant after one cycle.
REQ-032 Random req traffic for 10k cycles -> grants never both 1; s_* = 0 whenever arb_busy=0.
